// File: rtl/parking_lane_arbiter.sv
// Round-robin gate sequencer: one lane at a time through CHECK/OPEN/CLOSE, one car pulse per passage.
// Grant 1 cycle after a request is seen idle; pending lanes simply hold req (no queueing).
module parking_lane_arbiter #(
  parameter int N_LANES      = 4,
  parameter int PASS_TIMEOUT = 16,
  parameter int CLOSE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lot_open,
  input  logic [N_LANES-1:0] req,
  input  logic [N_LANES-1:0] req_exit,
  input  logic [N_LANES-1:0] req_uni,
  input  logic [N_LANES-1:0] pass_sensor,
  input  logic               uni_space_ok,
  input  logic               gen_space_ok,
  output logic [N_LANES-1:0] grant,
  output logic [N_LANES-1:0] gate_open,
  output logic [N_LANES-1:0] deny,
  output logic               car_entered,
  output logic               is_uni_car_entered,
  output logic               car_exited,
  output logic               is_uni_car_exited,
  output logic               busy,
  output logic [7:0]         timeout_cnt
);

  localparam int LW = $clog2(N_LANES);

  typedef enum logic [1:0] {IDLE, CHECK, OPEN, CLOSE} state_t;

  state_t             state, state_nxt;
  logic [LW-1:0]      lane, rr_ptr, scan_lane, lane_inc;
  logic               exit_flag, uni_flag;
  logic [7:0]         open_timer;
  logic [3:0]         close_timer;
  logic [N_LANES-1:0] eligible, lane_oh;
  logic               scan_hit;
  logic               do_latch, do_deny, do_pass, do_timeout;

  // Entries are invisible to the scan while the lot is closed; exits always compete.
  assign eligible = req & (req_exit | {N_LANES{lot_open}});

  always_comb begin
    logic [LW:0] idx;
    scan_hit  = 1'b0;
    scan_lane = '0;
    idx       = '0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = {1'b0, rr_ptr} + (LW+1)'(i);
      if (idx >= (LW+1)'(N_LANES)) idx = idx - (LW+1)'(N_LANES);
      if (!scan_hit && eligible[idx[LW-1:0]]) begin
        scan_hit  = 1'b1;
        scan_lane = idx[LW-1:0];
      end
    end
  end

  assign lane_inc = (lane == LW'(N_LANES-1)) ? '0 : lane + LW'(1);

  always_comb begin
    lane_oh       = '0;
    lane_oh[lane] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_latch   = 1'b0;
    do_deny    = 1'b0;
    do_pass    = 1'b0;
    do_timeout = 1'b0;
    grant      = '0;
    gate_open  = '0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (scan_hit) begin
          do_latch  = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        grant = lane_oh;
        // Space and lot hours are judged once here; later changes never abort the passage.
        if (exit_flag || (lot_open && (uni_flag ? uni_space_ok : gen_space_ok))) begin
          state_nxt = OPEN;
        end else begin
          do_deny   = 1'b1;
          state_nxt = IDLE;
        end
      end
      OPEN: begin
        grant     = lane_oh;
        gate_open = lane_oh;
        if (pass_sensor[lane]) begin
          do_pass   = 1'b1;
          state_nxt = CLOSE;
        end else if (open_timer == 8'(PASS_TIMEOUT-1)) begin
          do_timeout = 1'b1;
          state_nxt  = CLOSE;
        end
      end
      CLOSE: begin
        grant = lane_oh;
        if (close_timer == 4'(CLOSE_CYCLES-1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane               <= '0;
      exit_flag          <= 1'b0;
      uni_flag           <= 1'b0;
      rr_ptr             <= '0;
      open_timer         <= '0;
      close_timer        <= '0;
      timeout_cnt        <= '0;
      deny               <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
    end else begin
      if (do_latch) begin
        lane      <= scan_lane;
        exit_flag <= req_exit[scan_lane];
        uni_flag  <= req_uni[scan_lane];
      end
      open_timer  <= (state == OPEN)  ? open_timer + 8'd1  : 8'd0;
      close_timer <= (state == CLOSE) ? close_timer + 4'd1 : 4'd0;
      // Fairness: the lane just served (or refused) goes to the back of the scan order.
      if (do_deny || do_pass || do_timeout) rr_ptr <= lane_inc;
      if (do_timeout && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
      deny               <= do_deny ? lane_oh : '0;
      car_entered        <= do_pass & ~exit_flag;
      is_uni_car_entered <= do_pass & ~exit_flag & uni_flag;
      car_exited         <= do_pass & exit_flag;
      is_uni_car_exited  <= do_pass & exit_flag & uni_flag;
    end
  end

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Randomized bench for parking_lane_arbiter against a transaction-level lane-service model.
module tb_parking_lane_arbiter;

  localparam int N = 4;
  localparam int T = 16;
  localparam int C = 2;

  logic         clk;
  logic         rst;
  logic         lot_open;
  logic [N-1:0] req, req_exit, req_uni, pass_sensor;
  logic         uni_space_ok, gen_space_ok;
  logic [N-1:0] grant, gate_open, deny;
  logic         car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, busy;
  logic [7:0]   timeout_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;
  int m_to     = 0;

  parking_lane_arbiter #(.N_LANES(N), .PASS_TIMEOUT(T), .CLOSE_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .lot_open(lot_open), .req(req), .req_exit(req_exit),
    .req_uni(req_uni), .pass_sensor(pass_sensor), .uni_space_ok(uni_space_ok),
    .gen_space_ok(gen_space_ok), .grant(grant), .gate_open(gate_open), .deny(deny),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited), .busy(busy),
    .timeout_cnt(timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One service attempt, entered at a falling edge with the DUT idle.
  // d = OPEN cycle index at which the pass sensor fires (d >= T means never).
  task automatic txn(input logic [N-1:0] r, input logic [N-1:0] rx, input logic [N-1:0] ru,
                     input logic lo, input logic uo, input logic go, input int d, input bit jitter);
    int           lane;
    int           k;
    bit           ok;
    bit           passed;
    logic [N-1:0] oh;
    logic [N-1:0] ps;
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    chk("idle_timeouts", timeout_cnt, m_to);
    req = r; req_exit = rx; req_uni = ru; lot_open = lo;
    uni_space_ok = uo; gen_space_ok = go;
    pass_sensor = jitter ? N'($urandom) : '0;
    lane = -1;
    for (int i = 0; i < N; i++)
      if (lane < 0 && r[(m_rr + i) % N] && (rx[(m_rr + i) % N] || lo)) lane = (m_rr + i) % N;
    @(negedge clk);
    if (lane < 0) return;
    oh = '0;
    oh[lane] = 1'b1;
    chk("check_grant", grant, oh);
    chk("check_busy", busy, 1);
    chk("check_gate", gate_open, 0);
    chk("check_deny", deny, 0);
    if (jitter) begin
      lot_open = ($urandom % 4) != 0;
      uni_space_ok = ($urandom % 4) != 0;
      gen_space_ok = ($urandom % 4) != 0;
      req_uni = N'($urandom);
      pass_sensor = N'($urandom);
    end
    ok = rx[lane] || (lot_open && (ru[lane] ? uni_space_ok : gen_space_ok));
    @(negedge clk);
    if (!ok) begin
      chk("deny_pulse", deny, oh);
      chk("deny_gate", gate_open, 0);
      chk("deny_grant", grant, 0);
      chk("deny_car", {car_entered, car_exited}, 0);
      m_rr = (lane + 1) % N;
      return;
    end
    chk("open_deny", deny, 0);
    k = 0;
    while (1) begin
      chk("open_gate", gate_open, oh);
      chk("open_grant", grant, oh);
      chk("open_car", {car_entered, car_exited}, 0);
      ps = jitter ? N'($urandom) : '0;
      ps[lane] = (k == d);
      pass_sensor = ps;
      if (jitter) begin
        req = N'($urandom);
        lot_open = $urandom % 2;
        uni_space_ok = $urandom % 2;
        gen_space_ok = $urandom % 2;
      end
      if (k == d || k == T - 1) break;
      k++;
      @(negedge clk);
    end
    @(negedge clk);
    passed = (d < T);
    if (!passed && m_to < 255) m_to++;
    chk("pulse_entered", car_entered, passed && !rx[lane]);
    chk("pulse_uni_entered", is_uni_car_entered, passed && !rx[lane] && ru[lane]);
    chk("pulse_exited", car_exited, passed && rx[lane]);
    chk("pulse_uni_exited", is_uni_car_exited, passed && rx[lane] && ru[lane]);
    chk("close_gate", gate_open, 0);
    chk("close_grant", grant, oh);
    chk("close_timeouts", timeout_cnt, m_to);
    for (int c = 1; c < C; c++) begin
      @(negedge clk);
      chk("close_busy", busy, 1);
      chk("close_car", {car_entered, car_exited}, 0);
    end
    @(negedge clk);
    m_rr = (lane + 1) % N;
  endtask

  task automatic rand_txn();
    txn(N'($urandom), N'($urandom), N'($urandom), ($urandom % 4) != 0,
        ($urandom % 4) != 0, ($urandom % 4) != 0, $urandom_range(0, T + 2), 1'b1);
  endtask

  initial begin
    rst = 1'b1; lot_open = 1'b0; req = '0; req_exit = '0; req_uni = '0;
    pass_sensor = '0; uni_space_ok = 1'b0; gen_space_ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_deny", deny, 0);
    chk("rst_entered", car_entered, 0);
    chk("rst_uni_entered", is_uni_car_entered, 0);
    chk("rst_exited", car_exited, 0);
    chk("rst_uni_exited", is_uni_car_exited, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeouts", timeout_cnt, 0);
    rst = 1'b0;

    // Uni entry on lane 1, pass in the 4th open cycle.
    txn(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    // Round robin between lanes 0 and 2.
    repeat (3) txn(4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    // General entry refused on lane 3, then scan restarts at lane 0.
    txn(4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    txn(4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    // Lot closed: exit served, entry skipped until the lot opens.
    txn(4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    txn(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    txn(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    // Pass on the last open cycle beats the timeout; one cycle later is a timeout.
    txn(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, T - 1, 1'b0);
    txn(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, T, 1'b0);

    repeat (200) rand_txn();

    // Drive the timeout counter into saturation.
    repeat (258) txn(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, T, 1'b0);

    // Reset while lane 1 gate is open and its car is passing.
    chk("pre_rst_busy", busy, 0);
    req = 4'b0010; req_exit = 4'b0010; req_uni = 4'b0010; lot_open = 1'b1; pass_sensor = '0;
    @(negedge clk);
    chk("pre_rst_grant", grant, 4'b0010);
    @(negedge clk);
    chk("pre_rst_gate", gate_open, 4'b0010);
    rst = 1'b1;
    pass_sensor = 4'b0010;
    @(negedge clk);
    chk("mid_rst_gate", gate_open, 0);
    chk("mid_rst_exited", car_exited, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeouts", timeout_cnt, 0);
    rst = 1'b0;
    req = '0;
    pass_sensor = '0;
    m_rr = 0;
    m_to = 0;
    txn(4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b1, 1'b1, 1, 1'b0);

    repeat (40) rand_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_lane_arbiter.md
# parking_lane_arbiter

Sequences the parking lot's entry and exit lanes onto the single occupancy datapath. Lanes raise gate requests. A round-robin arbiter picks one lane at a time and checks class capacity for entries. It then opens that lane's gate and waits for the pass sensor. Exactly one car_entered or car_exited pulse is emitted per completed passage, so the occupancy counter never sees simultaneous events.

## Interface
Parameters:
- N_LANES, 4, number of lanes (2..8)
- PASS_TIMEOUT, 16, max cycles the gate stays open waiting for the pass sensor (2..255)
- CLOSE_CYCLES, 2, cycles the gate is held closed before the next grant (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- lot_open  in  1  1 = lot within operating hours (entries allowed)
- req  in  N_LANES  per-lane gate request, level, held until the lane is served
- req_exit  in  N_LANES  per lane: 1 = exit request, 0 = entry request
- req_uni  in  N_LANES  per lane: 1 = university car, 0 = general car
- pass_sensor  in  N_LANES  per lane: car has passed the gate (level)
- uni_space_ok  in  1  uni class has at least one free space
- gen_space_ok  in  1  general class has at least one free space
- grant  out  N_LANES  one-hot lane currently being served, 0 when idle
- gate_open  out  N_LANES  gate drive, at most one bit set
- deny  out  N_LANES  1-cycle pulse: entry refused for lack of space
- car_entered  out  1  1-cycle pulse to the occupancy datapath
- is_uni_car_entered  out  1  class of car_entered, valid with the pulse, else 0
- car_exited  out  1  1-cycle pulse to the occupancy datapath
- is_uni_car_exited  out  1  class of car_exited, valid with the pulse, else 0
- busy  out  1  state != IDLE
- timeout_cnt  out  8  count of gate timeouts, saturates at 255

## Operation
- FSM states: IDLE, CHECK, OPEN, CLOSE. Registers: lane index, exit flag, uni flag, rr pointer, open timer, close timer.
- **IDLE**
  - Scan lanes from rr pointer upward, wrapping modulo N_LANES.
  - A lane is eligible if req=1 and either req_exit=1 or lot_open=1.
  - Entry requests with lot_open=0 are skipped, not denied.
  - On the first eligible lane: latch lane, req_exit and req_uni, then go to CHECK.
- **CHECK** (1 cycle)
  - Exits always proceed to OPEN.
  - An entry proceeds to OPEN only if lot_open=1 and the space_ok for the latched class is 1.
  - Otherwise: deny[lane] pulses, rr pointer becomes lane+1 mod N_LANES, state returns to IDLE.
  - space_ok and lot_open are sampled only in CHECK. Changes during OPEN do not abort the passage.
- **OPEN**
  - Timer starts at 0 on entry to the state and increments each cycle.
  - If pass_sensor[lane]=1: registered car_entered or car_exited pulse, with the uni flag on the matching is_uni_* output; go to CLOSE.
  - Else if timer = PASS_TIMEOUT-1: go to CLOSE with no car pulse; timeout_cnt increments (saturating).
  - Pass has priority over timeout in the same cycle.
- **CLOSE**
  - Stay exactly CLOSE_CYCLES cycles, then go to IDLE.
  - rr pointer becomes lane+1 mod N_LANES.
- **Decoded outputs**
  - grant = onehot(lane) in CHECK, OPEN and CLOSE; 0 in IDLE.
  - gate_open[lane] = 1 only in OPEN.
- Requests from other lanes stay pending; no queueing beyond the req level.

## Timing
- Reset: state IDLE, rr pointer 0, timeout_cnt 0. grant, gate_open, deny, car_entered, car_exited, both is_uni_* and busy are all 0.
- Reset asserted mid-operation closes the gate on the next cycle and emits no car pulse.
- Latency (request seen in IDLE at cycle t):
  - CHECK at t+1.
  - gate_open at t+2.
  - For a pass seen at cycle p: car pulse and CLOSE at p+1; IDLE at p+1+CLOSE_CYCLES.
  - Deny: deny pulse and IDLE at t+2.
  - Timeout: OPEN lasts exactly PASS_TIMEOUT cycles.
- The next grant can start in the first IDLE cycle. Back-to-back passages are spaced by at least 3+CLOSE_CYCLES cycles.
- car_entered and car_exited are never both high; at most one pulse per grant.
- req dropping during OPEN has no effect; the gate stays open until pass or timeout.

## Test plan
- Uni entry: req[1]=1, req_exit[1]=0, req_uni[1]=1, uni_space_ok=1 at cycle 0; pass_sensor[1]=1 at cycle 5 -> grant=0010 at cycle 1, gate_open[1] cycles 2-5, car_entered=1 and is_uni_car_entered=1 at cycle 6, busy=0 at cycle 8.
- Round robin: req[0]=req[2]=1 (entries, space ok), each passes 2 cycles after its gate opens -> lane 0 served first, then lane 2, then lane 0 again if still requesting.
- Deny: req[3] general entry, gen_space_ok=0 -> deny[3]=1 at cycle 2, no gate_open; the next scan starts at lane 0.
- Timeout: exit on lane 2, pass_sensor held 0 -> gate_open[2] for exactly 16 cycles, no car pulse, timeout_cnt=1; 256 timeouts leave timeout_cnt=255.
- Lot closed: lot_open=0, req[0] entry and req[1] exit -> lane 1 gets car_exited; lane 0 is never granted until lot_open=1.
- Reset mid-OPEN: rst=1 during lane 1 OPEN -> gate_open=0 next cycle, no car pulse, timeout_cnt=0, rr pointer restarts at lane 0.
